// File: rtl/cache_flush_seq_pkg.sv
// Shared types for the whole-cache flush sequencer.
// Walk states; advancing to the next set is folded into the transitions.
package cache_flush_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WB,
        CLEAR,
        DONE
    } flush_state_t;

    localparam int WBCNT_W = 16;
    localparam logic [WBCNT_W-1:0] WBCNT_MAX = '1;

endpackage

// File: rtl/cache_flush_seq.sv
// Whole-cache flush sequencer: writes back dirty+valid ways set by set.
// Define FLUSH_WBCOUNT_EN to build the saturating writeback counter on WBCount.
module cache_flush_seq
    import cache_flush_seq_pkg::*;
#(
    parameter int NUMWAYS  = 4,
    parameter int SETLEN   = 9,
    parameter int NUMLINES = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushCache,
    input  logic               InvalidateEn,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [NUMWAYS-1:0] DirtyWay,
    input  logic               WBAck,
    output logic [SETLEN-1:0]  FlushAdr,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic               FlushRead,
    output logic               WBReq,
    output logic               ClearDirty,
    output logic               ClearValid,
    output logic               ReplClear,
    output logic               FlushBusy,
    output logic               FlushDone,
    output logic [15:0]        WBCount
);

    localparam logic [SETLEN-1:0]  LAST_SET = SETLEN'(NUMLINES - 1);
    localparam logic [NUMWAYS-1:0] ONE      = NUMWAYS'(1);

    flush_state_t       state;
    logic [SETLEN-1:0]  set;
    logic [NUMWAYS-1:0] pend;
    logic               inv;

    logic [NUMWAYS-1:0] dv;
    logic [NUMWAYS-1:0] low;
    logic [NUMWAYS-1:0] rest;
    logic               last;
    logic               ack;
    logic               adv;

    assign dv   = DirtyWay & ValidWay;
    // Two's-complement trick isolates the lowest pending way.
    assign low  = pend & (~pend + ONE);
    assign rest = pend & ~low;
    assign last = (set == LAST_SET);
    assign ack  = (state == WB) && WBAck;

    // A set is finished when nothing is left to write back or invalidate.
    assign adv = ((state == CHECK) && (dv == '0) && !inv)
              || (ack && (rest == '0) && !inv)
              || (state == CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            set   <= '0;
            pend  <= '0;
            inv   <= 1'b0;
        end else begin
            if (adv) begin
                if (last) begin
                    state <= DONE;
                end else begin
                    set   <= set + SETLEN'(1);
                    state <= READ;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (FlushCache) begin
                            inv   <= InvalidateEn;
                            set   <= '0;
                            state <= READ;
                        end
                    end
                    READ:  state <= CHECK;
                    CHECK: begin
                        pend  <= dv;
                        state <= (dv != '0) ? WB : CLEAR;
                    end
                    WB: begin
                        if (WBAck) begin
                            pend <= rest;
                            if (rest == '0) state <= CLEAR;
                        end
                    end
                    CLEAR: state <= IDLE;
                    DONE:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign FlushAdr   = set;
    assign FlushRead  = (state == READ);
    assign WBReq      = (state == WB);
    assign ClearDirty = ack;
    assign ClearValid = (state == CLEAR);
    assign ReplClear  = (state == CLEAR);
    assign FlushBusy  = (state != IDLE);
    assign FlushDone  = (state == DONE);

    always_comb begin
        FlushWay = '0;
        if (state == WB)    FlushWay = low;
        if (state == CLEAR) FlushWay = '1;
    end

`ifdef FLUSH_WBCOUNT_EN
    logic [WBCNT_W-1:0] wbcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wbcnt <= '0;
        end else if ((state == IDLE) && FlushCache) begin
            wbcnt <= '0;
        end else if (ack && (wbcnt != WBCNT_MAX)) begin
            wbcnt <= wbcnt + WBCNT_W'(1);
        end
    end

    assign WBCount = wbcnt;
`else
    assign WBCount = '0;
`endif

endmodule
